// File: rtl/openddr_bank_scheduler_v2_if.sv
// openddr_bank_scheduler_v2_if: request handshake and command bus of the bank scheduler
interface openddr_bank_scheduler_v2_if #(
    parameter int NUM_BANKS = 8,
    parameter int ROW_WIDTH = 16,
    parameter int COL_WIDTH = 10,
    parameter int ID_WIDTH  = 12
);
    localparam int BW = $clog2(NUM_BANKS);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [BW-1:0]        req_bank;
    logic [ROW_WIDTH-1:0] req_row;
    logic [COL_WIDTH-1:0] req_col;
    logic [ID_WIDTH-1:0]  req_id;
    logic                 cmd_valid;
    logic [2:0]           cmd_type;
    logic [BW-1:0]        cmd_bank;
    logic [ROW_WIDTH-1:0] cmd_addr;
    logic [ID_WIDTH-1:0]  cmd_id;
    modport master (
        output req_valid, req_write, req_bank, req_row, req_col, req_id,
        input  req_ready, cmd_valid, cmd_type, cmd_bank, cmd_addr, cmd_id
    );
    modport slave (
        input  req_valid, req_write, req_bank, req_row, req_col, req_id,
        output req_ready, cmd_valid, cmd_type, cmd_bank, cmd_addr, cmd_id
    );
endinterface

// File: rtl/openddr_bank_scheduler_v2.sv
// openddr_bank_scheduler_v2: open-page multi-bank DDR command scheduler with timing gates and periodic refresh
module openddr_bank_scheduler_v2 #(
    parameter int NUM_BANKS = 8,
    parameter int ROW_WIDTH = 16,
    parameter int COL_WIDTH = 10,
    parameter int ID_WIDTH  = 12,
    parameter int T_WIDTH   = 8
) (
    input  logic                  mck,
    input  logic                  mc_rst_b,
    openddr_bank_scheduler_v2_if.slave bus,
    input  logic [T_WIDTH-1:0]    cfg_trcd,
    input  logic [T_WIDTH-1:0]    cfg_trp,
    input  logic [T_WIDTH-1:0]    cfg_tras,
    input  logic [T_WIDTH-1:0]    cfg_trfc,
    input  logic [15:0]           cfg_trefi,
    output logic [NUM_BANKS-1:0]  bank_open,
    output logic                  ref_pending,
    output logic                  ref_overrun
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                           C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6;
    typedef enum logic [2:0] {IDLE, PRE, ACT, RW, REF_PREA, REF, REF_WAIT} state_e;
    state_e               state_q, state_d;
    logic [NUM_BANKS-1:0] open_q, open_d;
    logic [ROW_WIDTH-1:0] row_q [NUM_BANKS];
    logic [ROW_WIDTH-1:0] row_d [NUM_BANKS];
    logic [T_WIDTH-1:0]   tras_q [NUM_BANKS];
    logic [T_WIDTH-1:0]   tras_d [NUM_BANKS];
    logic [T_WIDTH-1:0]   trp_q [NUM_BANKS];
    logic [T_WIDTH-1:0]   trp_d [NUM_BANKS];
    logic [T_WIDTH-1:0]   trcd_q, trcd_d, trfc_q, trfc_d;
    logic [15:0]          trefi_q, trefi_d;
    logic                 pend_q, pend_d, ovr_q, ovr_d, ready_q, ready_d;
    logic                 wr_q, wr_d;
    logic [BW-1:0]        bank_q, bank_d;
    logic [ROW_WIDTH-1:0] rrow_q, rrow_d;
    logic [COL_WIDTH-1:0] col_q, col_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [2:0]           cmd_type_q, cmd_type_d;
    logic [BW-1:0]        cmd_bank_q, cmd_bank_d;
    logic [ROW_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [ID_WIDTH-1:0]  cmd_id_q, cmd_id_d;
    logic                 accept, expire, issue_ref, tras_idle, trp_idle;

    // Saturating decrement doubles as the load value max(cfg,1)-1.
    function automatic logic [T_WIDTH-1:0] sat_dec(input logic [T_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - T_WIDTH'(1);
    endfunction

    assign accept = bus.req_valid && ready_q;
    assign expire = (cfg_trefi != '0) && (trefi_q >= cfg_trefi - 16'd1);

    always_comb begin
        tras_idle = 1'b1;
        trp_idle = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            tras_idle &= (tras_q[i] == '0);
            trp_idle &= (trp_q[i] == '0);
            tras_d[i] = sat_dec(tras_q[i]);
            trp_d[i] = sat_dec(trp_q[i]);
        end
        state_d = state_q;
        open_d = open_q;
        row_d = row_q;
        trcd_d = sat_dec(trcd_q);
        trfc_d = sat_dec(trfc_q);
        wr_d = wr_q;
        bank_d = bank_q;
        rrow_d = rrow_q;
        col_d = col_q;
        id_d = id_q;
        cmd_valid_d = 1'b0;
        cmd_type_d = C_NOP;
        cmd_bank_d = '0;
        cmd_addr_d = '0;
        cmd_id_d = '0;
        issue_ref = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = |open_q ? REF_PREA : REF;
                end else if (accept) begin
                    wr_d = bus.req_write;
                    bank_d = bus.req_bank;
                    rrow_d = bus.req_row;
                    col_d = bus.req_col;
                    id_d = bus.req_id;
                    state_d = !open_q[bus.req_bank] ? ACT :
                              (row_q[bus.req_bank] == bus.req_row) ? RW : PRE;
                end
            end
            PRE: if (tras_q[bank_q] == '0) begin
                cmd_valid_d = 1'b1;
                cmd_type_d = C_PRE;
                cmd_bank_d = bank_q;
                open_d[bank_q] = 1'b0;
                trp_d[bank_q] = sat_dec(cfg_trp);
                state_d = ACT;
            end
            ACT: if (trp_q[bank_q] == '0) begin
                cmd_valid_d = 1'b1;
                cmd_type_d = C_ACT;
                cmd_bank_d = bank_q;
                cmd_addr_d = rrow_q;
                open_d[bank_q] = 1'b1;
                row_d[bank_q] = rrow_q;
                tras_d[bank_q] = sat_dec(cfg_tras);
                trcd_d = sat_dec(cfg_trcd);
                state_d = RW;
            end
            RW: if (trcd_q == '0) begin
                cmd_valid_d = 1'b1;
                cmd_type_d = wr_q ? C_WR : C_RD;
                cmd_bank_d = bank_q;
                cmd_addr_d = ROW_WIDTH'(col_q);
                cmd_id_d = id_q;
                state_d = IDLE;
            end
            REF_PREA: if (tras_idle) begin
                cmd_valid_d = 1'b1;
                cmd_type_d = C_PREA;
                open_d = '0;
                for (int i = 0; i < NUM_BANKS; i++) trp_d[i] = sat_dec(cfg_trp);
                state_d = REF;
            end
            REF: if (trp_idle) begin
                cmd_valid_d = 1'b1;
                cmd_type_d = C_REF;
                issue_ref = 1'b1;
                trfc_d = sat_dec(cfg_trfc);
                state_d = REF_WAIT;
            end
            REF_WAIT: if (trfc_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        trefi_d = (cfg_trefi == '0 || expire) ? '0 : trefi_q + 16'd1;
        // An expiry coinciding with REF issue starts a fresh pending refresh instead of overrunning.
        ovr_d = expire && pend_q && !issue_ref;
        pend_d = expire || (pend_q && !issue_ref);
        ready_d = (state_d == IDLE) && !pend_d;
    end

    always_ff @(posedge mck or negedge mc_rst_b) begin
        if (!mc_rst_b) begin
            state_q <= IDLE;
            open_q <= '0;
            row_q <= '{default: '0};
            tras_q <= '{default: '0};
            trp_q <= '{default: '0};
            trcd_q <= '0;
            trfc_q <= '0;
            trefi_q <= '0;
            pend_q <= 1'b0;
            ovr_q <= 1'b0;
            ready_q <= 1'b0;
            wr_q <= 1'b0;
            bank_q <= '0;
            rrow_q <= '0;
            col_q <= '0;
            id_q <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q <= C_NOP;
            cmd_bank_q <= '0;
            cmd_addr_q <= '0;
            cmd_id_q <= '0;
        end else begin
            state_q <= state_d;
            open_q <= open_d;
            row_q <= row_d;
            tras_q <= tras_d;
            trp_q <= trp_d;
            trcd_q <= trcd_d;
            trfc_q <= trfc_d;
            trefi_q <= trefi_d;
            pend_q <= pend_d;
            ovr_q <= ovr_d;
            ready_q <= ready_d;
            wr_q <= wr_d;
            bank_q <= bank_d;
            rrow_q <= rrow_d;
            col_q <= col_d;
            id_q <= id_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q <= cmd_type_d;
            cmd_bank_q <= cmd_bank_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_id_q <= cmd_id_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_type = cmd_type_q;
    assign bus.cmd_bank = cmd_bank_q;
    assign bus.cmd_addr = cmd_addr_q;
    assign bus.cmd_id = cmd_id_q;
    assign bank_open = open_q;
    assign ref_pending = pend_q;
    assign ref_overrun = ovr_q;
endmodule

// File: tb/tb_openddr_bank_scheduler_v2.sv
// tb_openddr_bank_scheduler_v2: directed checks of the bank scheduler
module tb_openddr_bank_scheduler_v2;
    logic        mck = 1'b0;
    logic        mc_rst_b = 1'b0;
    logic [7:0]  cfg_trcd, cfg_trp, cfg_tras, cfg_trfc;
    logic [15:0] cfg_trefi;
    logic [7:0]  bank_open;
    logic        ref_pending, ref_overrun;
    int          checks = 0, failures = 0, cyc = 0;
    int          a, a2, ov_n, ov_c;
    typedef struct {int t; int b; int a; int id; int c;} cmd_t;
    cmd_t cmdq[$];

    openddr_bank_scheduler_v2_if #(.NUM_BANKS(8), .ROW_WIDTH(16), .COL_WIDTH(10), .ID_WIDTH(12)) bus ();

    openddr_bank_scheduler_v2 #(.NUM_BANKS(8), .ROW_WIDTH(16), .COL_WIDTH(10), .ID_WIDTH(12), .T_WIDTH(8)) dut (
        .mck(mck), .mc_rst_b(mc_rst_b), .bus(bus),
        .cfg_trcd(cfg_trcd), .cfg_trp(cfg_trp), .cfg_tras(cfg_tras), .cfg_trfc(cfg_trfc),
        .cfg_trefi(cfg_trefi), .bank_open(bank_open), .ref_pending(ref_pending), .ref_overrun(ref_overrun)
    );

    always #5 mck = ~mck;
    always @(posedge mck or negedge mc_rst_b) cyc <= !mc_rst_b ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge mck) if (mc_rst_b) begin
        if (bus.cmd_valid)
            cmdq.push_back('{int'(bus.cmd_type), int'(bus.cmd_bank), int'(bus.cmd_addr), int'(bus.cmd_id), cyc});
        else
            check("nop_zero", {33'd0, bus.cmd_type, bus.cmd_addr, bus.cmd_id}, 64'd0);
    end

    task automatic expect_cmd(input string tag, input int t, input int b, input int ad, input int id, input int c);
        cmd_t e;
        int n = 0;
        while (cmdq.size() == 0 && n < 400) begin
            @(negedge mck);
            #1;
            n++;
        end
        if (cmdq.size() == 0) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        e = cmdq.pop_front();
        check({tag, "_type"}, e.t, t);
        check({tag, "_bank"}, e.b, b);
        check({tag, "_addr"}, e.a, ad);
        check({tag, "_id"}, e.id, id);
        check({tag, "_cyc"}, e.c, c);
    endtask

    task automatic send(input logic w, input int b, input int r, input int c, input int id, output int acc);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_bank = 3'(b);
        bus.req_row = 16'(r);
        bus.req_col = 10'(c);
        bus.req_id = 12'(id);
        while (!bus.req_ready && n < 400) begin
            @(negedge mck);
            n++;
        end
        if (!bus.req_ready) begin
            check("send_timeout", 64'd0, 64'd1);
            acc = -1;
        end else begin
            acc = cyc + 1;
            @(negedge mck);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge mck);
    endtask

    task automatic do_reset();
        @(negedge mck);
        mc_rst_b = 1'b0;
        #1;
        check("rst_outs", {bus.cmd_valid, bus.cmd_type, bus.cmd_bank, bus.cmd_addr, bus.cmd_id,
                           bank_open, ref_pending, ref_overrun, bus.req_ready}, 64'd0);
        repeat (2) @(negedge mck);
        cmdq.delete();
        mc_rst_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_bank = '0;
        bus.req_row = '0;
        bus.req_col = '0;
        bus.req_id = '0;
        cfg_trcd = 8'd3;
        cfg_trp = 8'd2;
        cfg_tras = 8'd8;
        cfg_trfc = 8'd10;
        cfg_trefi = 16'd0;
        do_reset();
        // closed-bank read, then row-hit write
        send(1'b0, 2, 'h12, 'h5, 'hABC, a);
        expect_cmd("t1_act", 1, 2, 'h12, 0, a + 1);
        expect_cmd("t1_rd", 2, 2, 'h5, 'hABC, a + 4);
        check("t1_open", bank_open, 8'b0000_0100);
        send(1'b1, 2, 'h12, 'h33, 'h111, a);
        expect_cmd("t2_wr", 3, 2, 'h33, 'h111, a + 1);
        // row miss waiting on tRAS
        cfg_tras = 8'd20;
        send(1'b0, 0, 'h1, 'h2, 'h7, a);
        expect_cmd("t3_act0", 1, 0, 'h1, 0, a + 1);
        expect_cmd("t3_rd0", 2, 0, 'h2, 'h7, a + 4);
        send(1'b0, 0, 'h2, 'h9, 'h22, a2);
        check("t3_acc", a2, a + 5);
        expect_cmd("t3_pre", 4, 0, 0, 0, a + 21);
        expect_cmd("t3_act", 1, 0, 'h2, 0, a + 23);
        expect_cmd("t3_rd", 2, 0, 'h9, 'h22, a + 26);
        check("t3_open", bank_open, 8'b0000_0101);
        // refresh with two banks open, request held during refresh
        cfg_trcd = 8'd1;
        cfg_tras = 8'd3;
        cfg_trp = 8'd2;
        cfg_trfc = 8'd10;
        cfg_trefi = 16'd100;
        do_reset();
        send(1'b0, 1, 'h5, 'h0, 'h1, a);
        expect_cmd("t4_act1", 1, 1, 'h5, 0, a + 1);
        expect_cmd("t4_rd1", 2, 1, 0, 'h1, a + 2);
        send(1'b0, 4, 'h7, 'h0, 'h2, a);
        expect_cmd("t4_act4", 1, 4, 'h7, 0, a + 1);
        expect_cmd("t4_rd4", 2, 4, 0, 'h2, a + 2);
        check("t4_open2", bank_open, 8'b0001_0010);
        wait_cyc(99);
        check("t4_pend_early", ref_pending, 1'b0);
        @(negedge mck);
        check("t4_pend", ref_pending, 1'b1);
        check("t4_ready_low", bus.req_ready, 1'b0);
        send(1'b1, 1, 'h5, 'h3, 'h55, a);
        check("t4_acc", a, 115);
        check("t4_open_clr", bank_open, 8'd0);
        check("t4_pend_clr", ref_pending, 1'b0);
        expect_cmd("t4_prea", 5, 0, 0, 0, 102);
        expect_cmd("t4_ref", 6, 0, 0, 0, 104);
        expect_cmd("t4_act", 1, 1, 'h5, 0, 116);
        expect_cmd("t4_wr", 3, 1, 'h3, 'h55, 117);
        // overrun during a long tRAS-bound miss
        cfg_trefi = 16'd20;
        cfg_tras = 8'd40;
        cfg_trp = 8'd2;
        cfg_trcd = 8'd1;
        do_reset();
        send(1'b0, 3, 'h1, 'h0, 'h3, a);
        send(1'b0, 3, 'h2, 'h0, 'h4, a2);
        check("t5_acc", a2, a + 3);
        ov_n = 0;
        ov_c = 0;
        while (cyc < 55) begin
            @(negedge mck);
            if (ref_overrun) begin
                ov_n++;
                ov_c = cyc;
            end
        end
        check("t5_ov_count", ov_n, 1);
        check("t5_ov_cyc", ov_c, 40);
        expect_cmd("t5_act", 1, 3, 'h1, 0, a + 1);
        expect_cmd("t5_rd", 2, 3, 0, 'h3, a + 2);
        expect_cmd("t5_pre", 4, 3, 0, 0, a + 41);
        // reset between ACT and RD drops the request
        cfg_trefi = 16'd0;
        cfg_trcd = 8'd5;
        do_reset();
        send(1'b0, 2, 'h9, 'h4, 'h66, a);
        expect_cmd("t6_act", 1, 2, 'h9, 0, a + 1);
        wait_cyc(a + 3);
        mc_rst_b = 1'b0;
        #1;
        check("t6_rst", {bus.cmd_valid, bus.cmd_type, bus.cmd_addr, bus.cmd_id, bank_open,
                         ref_pending, ref_overrun, bus.req_ready}, 64'd0);
        repeat (2) @(negedge mck);
        mc_rst_b = 1'b1;
        repeat (20) @(negedge mck);
        check("t6_no_rd", cmdq.size(), 0);
        check("t6_ready", bus.req_ready, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/openddr_bank_scheduler_v2.md
Name: openddr_bank_scheduler_v2

Overview:
Parametrised command scheduler that replaces the fixed single-bank scheduler in the OpenDDR controller. It takes decoded requests (bank/row/col) from the AXI front end, one at a time with a valid/ready handshake. It tracks the open row in each of NUM_BANKS banks and issues ACT/RD/WR/PRE/PREA/REF commands, enforcing runtime-programmable tRCD, tRP, tRAS and tRFC spacing. Periodic refresh is driven by an internal tREFI timer; the DFI slot mapper downstream consumes its output.

Parameters:
NUM_BANKS, 8, number of banks tracked (power of 2, 2..16)
ROW_WIDTH, 16, row address width
COL_WIDTH, 10, column address width (must be <= ROW_WIDTH)
ID_WIDTH, 12, request tag width
T_WIDTH, 8, width of tRCD/tRP/tRAS/tRFC config fields

Ports:
mck  in  1  controller clock, all logic on rising edge
mc_rst_b  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1=write, 0=read
req_bank  in  $clog2(NUM_BANKS)  target bank
req_row  in  ROW_WIDTH  target row
req_col  in  COL_WIDTH  target column
req_id  in  ID_WIDTH  tag returned with RD/WR command
cfg_trcd / cfg_trp / cfg_tras / cfg_trfc  in  T_WIDTH each  timing values in mck cycles (0 treated as 1)
cfg_trefi  in  16  refresh interval in cycles; 0 disables refresh
cmd_valid  out  1  one-cycle command strobe
cmd_type  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF
cmd_bank  out  $clog2(NUM_BANKS)  command bank
cmd_addr  out  ROW_WIDTH  row for ACT, zero-extended col for RD/WR, 0 otherwise
cmd_id  out  ID_WIDTH  req_id for RD/WR, 0 otherwise
bank_open  out  NUM_BANKS  per-bank open-row flag
ref_pending  out  1  refresh requested, not yet issued
ref_overrun  out  1  one-cycle pulse: tREFI expired while ref_pending already set

Behaviour:
- Reset: FSM in IDLE, all banks closed, all counters 0, every output 0 (cmd_type=NOP).
- All outputs are registered. cmd_valid=0 implies cmd_type=0, cmd_addr=0, cmd_id=0.
- req_ready = (state==IDLE) && !ref_pending. The request fields are latched on acceptance; one request is in flight at a time.
- Timing counters count down to 0 and saturate there.
  - Each command loads the relevant counter with max(cfg,1)-1.
  - A dependent command may issue in a cycle only when its counter is 0, so consecutive dependent commands are spaced exactly max(cfg,1) cycles apart.
- Per-bank counters:
  - tRAS counter: loaded on ACT to that bank; gates PRE of that bank.
  - tRP counter: loaded on PRE of that bank, and on PREA for all banks; gates ACT of that bank.
- Global counters: a tRCD counter (gates RD/WR after ACT) and a tRFC counter (gates any command after REF).
- FSM states: IDLE, PRE, ACT, RW, REF_PREA, REF, REF_WAIT.
- IDLE, with ref_pending set:
  - Any bank open -> REF_PREA.
  - No bank open -> REF.
- IDLE, on request acceptance in cycle N:
  - Row hit (bank open, same row) -> RW. RD/WR issues at N+1.
  - Bank closed -> ACT. ACT issues at N+1 if that bank's tRP counter is 0; RD/WR issues tRCD cycles after ACT.
  - Row miss -> PRE. PRE issues at the first cycle >= N+1 with the bank's tRAS counter at 0. Then ACT follows tRP later, then RD/WR follows tRCD later.
- PRE clears bank_open[b]. ACT sets bank_open[b] and records the row. RD/WR leaves the row open (open-page policy) and returns the FSM to IDLE in the same cycle.
- REF_PREA: wait until all tRAS counters are 0, issue PREA (cmd_bank=0), clear all bank_open, go to REF.
- REF: wait until all tRP counters are 0, issue REF, clear ref_pending, load tRFC, go to REF_WAIT.
- REF_WAIT: when the tRFC counter reaches 0, go to IDLE.
- Refresh timer:
  - Counts up from 0 every cycle while cfg_trefi != 0.
  - On reaching cfg_trefi-1: resets to 0 and sets ref_pending. If ref_pending is already set, it pulses ref_overrun instead.
  - Writing cfg_trefi=0 holds the timer at 0; a pending refresh is still serviced.
- Simultaneous events:
  - If ref_pending rises in the same cycle a request is accepted, the request completes first, then the refresh runs.
  - A request held on req_valid while refresh is pending waits with ready low; its fields must stay stable per valid/ready rules.
- Reset mid-operation: returns everything immediately to the reset values; an in-flight request is dropped with no command issued.

Test Plan:
- Closed-bank read: tRCD=3, request bank2/row 0x12/col 0x5 accepted cycle 10 -> ACT(bank2, 0x0012) at cycle 11; RD(bank2, 0x0005, id) at cycle 14; bank_open=8'b00000100.
- Row hit: after the previous test, write to bank2/row 0x12 accepted cycle 20 -> WR at cycle 21 with no ACT/PRE.
- Row miss honouring tRAS: tRAS=8, tRP=2, tRCD=3; ACT bank0 at cycle 5, miss request accepted cycle 6 -> PRE at 13, ACT at 15, RD at 18.
- Refresh: cfg_trefi=100, two banks open, tRP=2, tRFC=10 -> ref_pending at cycle 100; PREA, then REF 2 cycles later; req_ready stays low until 10 cycles after REF; bank_open=0.
- Overrun: cfg_trefi=20, hold the FSM in a long miss sequence (tRAS=40) -> ref_overrun pulses exactly once at the second expiry.
- Reset mid-sequence: assert mc_rst_b low between ACT and RD -> all outputs 0 next edge; after release, no RD is ever issued for the dropped request.
